serial_tx: RTL and testbench
============================

# serial_tx

Parallel-to-serial transmitter: accepts a WIDTH-bit word over a LOAD/READY handshake and shifts it out on a single line as a framed asynchronous serial stream. The frame is start bit, data LSB first, optional parity, stop bit. It is the sending end of the lab's serial link, driven by register/FF-based datapaths and feeding the matching serial receiver on another board or block. The output is fully registered: every output bit comes from a D-FF with asynchronous reset.

## Interface
Parameters:
- WIDTH, 8, data bits per frame (1..16)
- DIV, 4, clock cycles per serial bit (2..65535)

Ports:
- CLK  input  1  clock, rising-edge active
- RESET  input  1  reset; asynchronous, active-low
- DIN  input  WIDTH  word to transmit; sampled only on an accepted LOAD
- LOAD  input  1  request to send DIN
- READY  output  1  high = idle, and LOAD will be accepted at the next rising edge
- SOUT  output  1  serial line; idle level 1
- BUSY  output  1  high while a frame is on SOUT
- DONE  output  1  one-cycle pulse when a frame completes

## Operation
- RESET=0 (asynchronous, independent of CLK) forces the following:
  - state = IDLE
  - SOUT=1, READY=1, BUSY=0, DONE=0
  - bit counter = 0, divider counter = 0, shift register = 0
- An in-flight frame is aborted and not resumed. The line returns to 1 immediately.
- States: IDLE → START → DATA → (PARITY) → STOP → IDLE.
- IDLE:
  - SOUT=1, READY=1.
  - On a rising edge with LOAD=1: latch DIN into the shift register, go to START, and set SOUT=0, READY=0, BUSY=1.
- START: SOUT=0 for DIV cycles, then go to DATA.
- DATA:
  - SOUT = shift register bit 0.
  - Every DIV cycles, shift right and increment the bit counter.
  - After WIDTH bits, go to PARITY if it is compiled in, otherwise to STOP.
- PARITY: SOUT = XOR of all latched data bits (even parity) for DIV cycles, then go to STOP.
- STOP:
  - SOUT=1 for DIV cycles.
  - Then go to IDLE with READY=1, BUSY=0, and DONE=1 for exactly one cycle.
- LOAD while READY=0 is ignored. It is not queued, and DIN changes are not observed.
- The divider counter counts 0..DIV-1 and wraps to 0 on each bit boundary. It has ceil(log2(DIV)) bits, minimum 1.
- The bit counter counts 0..WIDTH-1 and is cleared on entering DATA.

## Timing
- Edge 0 is the rising edge with LOAD=1 and READY=1.
- SOUT falls to 0 at edge 0, so the first-bit latency is 0 cycles after acceptance (registered output).
- Data bit k occupies edges (1+k)·DIV through (2+k)·DIV−1.
- Frame length F = (WIDTH+2)·DIV cycles, or (WIDTH+3)·DIV with parity.
- At edge F:
  - SOUT stays 1, READY=1, BUSY=0, DONE=1.
  - DONE falls at edge F+1.
- Back-to-back: a LOAD held high at edge F+1 starts the next frame, so the minimum inter-frame gap is one idle cycle at SOUT=1.
- LOAD=1 continuously gives one frame every F+1 cycles.
- A RESET assertion mid-frame takes effect without a clock edge. On deassertion, the block waits in IDLE; the first edge with LOAD=1 may start a frame.

## Configuration
- Macro SERIAL_TX_PARITY_EN.
- When defined:
  - PARITY state present.
  - One even-parity bit follows the data bits.
  - F = (WIDTH+3)·DIV.
- When undefined:
  - No PARITY state or logic; DATA goes directly to STOP.
  - F = (WIDTH+2)·DIV.
- The port list is identical in both builds.

## Test plan
- Idle after reset:
  - Stimulus: RESET=0 for 12 ns, then 1, with LOAD=0 for 100 cycles.
  - Required: SOUT=1, READY=1, BUSY=0, DONE=0 throughout.
- Single frame, no parity (WIDTH=8, DIV=4):
  - Stimulus: DIN=8'hA5 with a one-cycle LOAD.
  - Required:
    - SOUT over 40 cycles in 4-cycle groups: 0,1,0,1,0,0,1,0,1,1.
    - DONE pulses at cycle 40; READY=1 from cycle 40.
- Parity build:
  - Stimulus: DIN=8'h07.
  - Required: parity bit = 1, frame length 44 cycles.
  - Stimulus: DIN=8'hA5.
  - Required: parity bit = 0.
- LOAD while busy:
  - Stimulus: DIN=8'h3C accepted; at cycle 10, DIN=8'hFF with LOAD=1 for 1 cycle.
  - Required: the frame still carries 8'h3C, and no second frame follows.
- Back-to-back:
  - Stimulus: LOAD held at 1 with DIN=8'h01, then DIN=8'h80.
  - Required: second start bit at cycle 41, exactly 1 idle cycle at SOUT=1 between frames.
- Async reset mid-frame:
  - Stimulus: RESET=0 at 3 ns after the edge during data bit 3.
  - Required: SOUT=1, BUSY=0, READY=1 immediately, with no clock edge needed; the next LOAD sends a full, correct frame.

Source files
------------

// File: rtl/serial_tx.sv
// Framed asynchronous serial transmitter: start bit, WIDTH data bits LSB first,
// optional even parity (define SERIAL_TX_PARITY_EN), stop bit; DIV clocks per bit.
module serial_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DIN,
    input  logic             LOAD,
    output logic             READY,
    output logic             SOUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state_q, state_d;
    logic [DW-1:0]     div_q, div_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic              sout_q, sout_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
    logic              par_q, par_d;
`endif
    logic              bit_end;

    assign bit_end = (div_q == DW'(DIV - 1));

    // SOUT is computed one step ahead so the registered line changes on the
    // same edge the state does (start bit appears at the accepting edge).
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sout_d  = sout_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                sout_d  = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (LOAD) begin
                    shreg_d = DIN;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = ^DIN;
`endif
                    div_d   = '0;
                    state_d = START;
                    sout_d  = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    sout_d  = shreg_q[0];
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    div_d   = '0;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BW'(WIDTH - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
                        sout_d  = par_q;
`else
                        state_d = STOP;
                        sout_d  = 1'b1;
`endif
                    end else begin
                        bit_d  = bit_q + BW'(1);
                        sout_d = shreg_d[0];
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    div_d   = '0;
                    state_d = STOP;
                    sout_d  = 1'b1;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    div_d   = '0;
                    state_d = IDLE;
                    sout_d  = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                sout_d  = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sout_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sout_q  <= sout_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign SOUT  = sout_q;
    assign READY = ready_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Testbench for serial_tx; builds with or without SERIAL_TX_PARITY_EN.
module tb_serial_tx;

    localparam int W = 8;
    localparam int D = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NSLOT = W + 3;
`else
    localparam int NSLOT = W + 2;
`endif
    localparam int F = NSLOT * D;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic [W-1:0] DIN = '0;
    logic         LOAD = 1'b0;
    logic         READY, SOUT, BUSY, DONE;

    int n_checks = 0;
    int n_fail   = 0;
    logic last_sout [0:F-1];

    serial_tx #(.WIDTH(W), .DIV(D)) dut (
        .CLK(CLK), .RESET(RESET), .DIN(DIN), .LOAD(LOAD),
        .READY(READY), .SOUT(SOUT), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: value on the line during slot s of a frame carrying d.
    function automatic logic exp_slot(input logic [W-1:0] d, input int s);
        int unsigned v;
        v = d;
        if (s == 0) return 1'b0;
        if (s <= W) return ((v >> (s - 1)) % 2) == 1;
`ifdef SERIAL_TX_PARITY_EN
        if (s == W + 1) return ($countones(d) % 2) == 1;
`endif
        return 1'b1;
    endfunction

    // Called at a negedge; edge 0 is the next rising edge.
    task automatic frame(input logic [W-1:0] data, input bit hold,
                         input logic [W-1:0] next_din, input int inj_cycle,
                         input logic [W-1:0] inj_din);
        logic [3:0] got, req;
        DIN  = data;
        LOAD = 1'b1;
        for (int c = 0; c <= F; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (c == 0) begin
                if (hold) DIN = next_din;
                else LOAD = 1'b0;
            end
            if (c == inj_cycle - 1) begin
                DIN  = inj_din;
                LOAD = 1'b1;
            end
            if (c == inj_cycle) LOAD = 1'b0;
            got = {SOUT, BUSY, READY, DONE};
            if (c < F) begin
                last_sout[c] = SOUT;
                req = {exp_slot(data, c / D), 1'b1, 1'b0, 1'b0};
            end else begin
                req = 4'b1011;
            end
            n_checks++;
            if (got !== req) begin
                n_fail++;
                $display("FAIL frame din=%h cycle=%0d sout/busy/ready/done got=%b required=%b",
                         data, c, got, req);
            end
        end
        if (!hold) begin
            @(posedge CLK);
            @(negedge CLK);
            got = {SOUT, BUSY, READY, DONE};
            n_checks++;
            if (got !== 4'b1010) begin
                n_fail++;
                $display("FAIL done_fall din=%h got=%b required=1010", data, got);
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] got;
        #12 RESET = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            got = {SOUT, BUSY, READY, DONE};
            n_checks++;
            if (got !== 4'b1010) begin
                n_fail++;
                $display("FAIL reset_idle cycle=%0d got=%b required=1010", i, got);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [9:0] pat;
        pat = 10'b1101001010; // slot 0 in bit 0: 0,1,0,1,0,0,1,0,1 then stop
        frame(8'hA5, 1'b0, '0, -1, '0);
        for (int s = 0; s < 9; s++) begin
            n_checks++;
            if (last_sout[s * D + D / 2] !== pat[s]) begin
                n_fail++;
                $display("FAIL a5_slot%0d got=%b required=%b", s, last_sout[s * D + D / 2], pat[s]);
            end
        end
        n_checks++;
        if (last_sout[F - 1] !== 1'b1) begin
            n_fail++;
            $display("FAIL a5_stop got=%b required=1", last_sout[F - 1]);
        end
    endtask

`ifdef SERIAL_TX_PARITY_EN
    task automatic test_parity();
        frame(8'h07, 1'b0, '0, -1, '0);
        n_checks++;
        if (last_sout[(W + 1) * D + 1] !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_07 got=%b required=1", last_sout[(W + 1) * D + 1]);
        end
        frame(8'hA5, 1'b0, '0, -1, '0);
        n_checks++;
        if (last_sout[(W + 1) * D + 1] !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_a5 got=%b required=0", last_sout[(W + 1) * D + 1]);
        end
    endtask
`endif

    task automatic test_load_busy();
        logic [1:0] got;
        frame(8'h3C, 1'b0, '0, 10, 8'hFF);
        for (int i = 0; i < 2 * F; i++) begin
            @(negedge CLK);
            got = {SOUT, BUSY};
            n_checks++;
            if (got !== 2'b10) begin
                n_fail++;
                $display("FAIL load_busy_no_second cycle=%0d sout/busy got=%b required=10", i, got);
            end
        end
    endtask

    task automatic test_back_to_back();
        frame(8'h01, 1'b1, 8'h80, -1, '0);
        frame(8'h80, 1'b0, '0, -1, '0);
    endtask

    task automatic test_random();
        logic [W-1:0] d, nx;
        bit h;
        nx = W'($urandom);
        for (int i = 0; i < 16; i++) begin
            d  = nx;
            nx = W'($urandom);
            h  = (i < 15) && ($urandom_range(0, 1) == 1);
            frame(d, h, nx, -1, '0);
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] d;
        logic [2:0]   got;
        d    = W'($urandom);
        DIN  = d;
        LOAD = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        LOAD = 1'b0;
        repeat (4 * D) @(posedge CLK);
        #1;
        n_checks++;
        if (SOUT !== d[3]) begin
            n_fail++;
            $display("FAIL async_pre_bit3 got=%b required=%b", SOUT, d[3]);
        end
        #2 RESET = 1'b0;
        #1;
        got = {SOUT, BUSY, READY};
        n_checks++;
        if (got !== 3'b101) begin
            n_fail++;
            $display("FAIL async_reset_immediate sout/busy/ready got=%b required=101", got);
        end
        @(negedge CLK);
        RESET = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            got = {SOUT, BUSY, READY};
            n_checks++;
            if (got !== 3'b101) begin
                n_fail++;
                $display("FAIL async_post_idle got=%b required=101", got);
            end
        end
        frame(W'($urandom), 1'b0, '0, -1, '0);
    endtask

    initial begin
        test_reset();
        test_single_frame();
`ifdef SERIAL_TX_PARITY_EN
        test_parity();
`endif
        test_load_busy();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
